// File: rtl/cache_pkg.sv
// Shared types and address-field constants for the direct-mapped cache controller.
// One 32-bit word per line: tag = addr[31:14], index = addr[13:2].
package cache_pkg;

  localparam int TAG_LSB     = 14;
  localparam int INDEX_LSB   = 2;
  localparam int INDEX_WIDTH = 12;
  localparam int TAG_WIDTH   = 18;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COMPARE,
    ST_WRITEBACK,
    ST_FETCH,
    ST_REFILL
  } cache_state_e;

endpackage

// File: rtl/cache_stats.sv
// Pair of saturating event counters for cache hit/miss statistics.
// Only instantiated when CACHE_CTRL_STATS_EN is defined.
module cache_stats (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hit_i,
  input  logic        miss_i,
  output logic [31:0] stat_hits_o,
  output logic [31:0] stat_misses_o
);

  logic [31:0] hits_q;
  logic [31:0] misses_q;

  // Counters stop at all-ones instead of wrapping back to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hits_q   <= '0;
      misses_q <= '0;
    end else begin
      if (hit_i && (hits_q != '1))
        hits_q <= hits_q + 32'd1;
      if (miss_i && (misses_q != '1))
        misses_q <= misses_q + 32'd1;
    end
  end

  assign stat_hits_o   = hits_q;
  assign stat_misses_o = misses_q;

endmodule

// File: rtl/cache_ctrl.sv
// Write-back, write-allocate controller for a direct-mapped one-word-per-line cache.
// Optional hit/miss counters are built when CACHE_CTRL_STATS_EN is defined.
module cache_ctrl
  import cache_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = ADDR_WIDTH - TAG_LSB
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cpu_req,
  input  logic [DATA_WIDTH/8-1:0] cpu_we,
  input  logic [ADDR_WIDTH-1:0]   cpu_addr,
  input  logic [DATA_WIDTH-1:0]   cpu_wdata,
  output logic [DATA_WIDTH-1:0]   cpu_rdata,
  output logic                    cpu_ready,
  output logic                    cm_en,
  output logic [DATA_WIDTH/8-1:0] cm_we,
  output logic                    cm_allocate,
  output logic [ADDR_WIDTH-1:0]   cm_addr,
  output logic [DATA_WIDTH-1:0]   cm_wdata,
  input  logic [DATA_WIDTH-1:0]   cm_rdata,
  input  logic                    cm_hit,
  input  logic                    cm_dirty,
  input  logic [TAG_WIDTH-1:0]    cm_victim_tag,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  input  logic                    mem_ready
`ifdef CACHE_CTRL_STATS_EN
  ,
  output logic [31:0]             stat_hits,
  output logic [31:0]             stat_misses
`endif
);

  localparam int BE_WIDTH = DATA_WIDTH / 8;

  cache_state_e            state_q;
  logic [ADDR_WIDTH-1:0]   req_addr_q;
  logic [BE_WIDTH-1:0]     req_we_q;
  logic [DATA_WIDTH-1:0]   req_wdata_q;
  logic [ADDR_WIDTH-1:0]   victim_addr_q;
  logic [DATA_WIDTH-1:0]   victim_data_q;
  logic [DATA_WIDTH-1:0]   refill_buf_q;

  // NOTE: every register here updates with <= so all of them sample the
  // pre-edge values of each other; blocking assignments would chain them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      req_addr_q    <= '0;
      req_we_q      <= '0;
      req_wdata_q   <= '0;
      victim_addr_q <= '0;
      victim_data_q <= '0;
      refill_buf_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cpu_req) begin
            req_addr_q  <= cpu_addr;
            req_we_q    <= cpu_we;
            req_wdata_q <= cpu_wdata;
            state_q     <= ST_COMPARE;
          end
        end
        ST_COMPARE: begin
          if (cm_hit) begin
            state_q <= ST_IDLE;
          end else if (cm_dirty) begin
            // Victim shares the request's index; only its stored tag differs.
            victim_addr_q <= {cm_victim_tag, req_addr_q[TAG_LSB-1:INDEX_LSB],
                              {INDEX_LSB{1'b0}}};
            victim_data_q <= cm_rdata;
            state_q       <= ST_WRITEBACK;
          end else begin
            state_q <= ST_FETCH;
          end
        end
        ST_WRITEBACK: begin
          if (mem_ready)
            state_q <= ST_FETCH;
        end
        ST_FETCH: begin
          if (mem_ready) begin
            refill_buf_q <= mem_rdata;
            state_q      <= ST_REFILL;
          end
        end
        ST_REFILL: begin
          state_q <= ST_COMPARE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // NOTE: every output gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    cpu_rdata   = '0;
    cpu_ready   = 1'b0;
    cm_en       = 1'b0;
    cm_we       = '0;
    cm_allocate = 1'b0;
    cm_addr     = '0;
    cm_wdata    = '0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    case (state_q)
      ST_COMPARE: begin
        cm_en   = 1'b1;
        cm_addr = req_addr_q;
        if (cm_hit) begin
          cm_we     = req_we_q;
          cm_wdata  = req_wdata_q;
          cpu_rdata = cm_rdata;
          cpu_ready = 1'b1;
        end
      end
      ST_WRITEBACK: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = victim_addr_q;
        mem_wdata = victim_data_q;
      end
      ST_FETCH: begin
        mem_req  = 1'b1;
        mem_addr = {req_addr_q[ADDR_WIDTH-1:INDEX_LSB], {INDEX_LSB{1'b0}}};
      end
      ST_REFILL: begin
        cm_en       = 1'b1;
        cm_allocate = 1'b1;
        cm_we       = '1;
        cm_wdata    = refill_buf_q;
        cm_addr     = req_addr_q;
      end
      default: ;
    endcase
  end

`ifdef CACHE_CTRL_STATS_EN
  // Marks the COMPARE that replays an access after a refill, so it is not a hit.
  logic replay_q;
  logic hit_pulse;
  logic miss_pulse;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      replay_q <= 1'b0;
    else if (state_q == ST_REFILL)
      replay_q <= 1'b1;
    else if (state_q == ST_IDLE)
      replay_q <= 1'b0;
  end

  assign hit_pulse  = (state_q == ST_COMPARE) && cm_hit && !replay_q;
  assign miss_pulse = (state_q == ST_COMPARE) && !cm_hit;

  cache_stats u_stats (
    .clk           (clk),
    .rst_n         (rst_n),
    .hit_i         (hit_pulse),
    .miss_i        (miss_pulse),
    .stat_hits_o   (stat_hits),
    .stat_misses_o (stat_misses)
  );
`endif

endmodule
